// File: rtl/alu_issue_ctrl.sv
// Single-issue controller around a registered 64-bit ALU: decodes one instruction,
// fetches operands from a 32x64 register file, and writes the ALU result back.
//
// state | meaning
// IDLE  | ready to accept an instruction (in_ready=1)
// EXEC  | alu_en high for this one cycle, ALU computing
// WB    | alu_result valid; written to reg[rd] at the end of this cycle
module alu_issue_ctrl #(
    parameter int NREGS = 32,
    parameter int XLEN  = 64,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            alu_en,
    output logic [7:0]      alu_opcode,
    output logic [XLEN-1:0] alu_operand1,
    output logic [XLEN-1:0] alu_operand2,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err_illegal,
    output logic            err_div0,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [7:0] OP_ADDI = 8'd1;
    localparam logic [7:0] OP_DIV  = 8'd4;
    localparam logic [7:0] OP_LUI  = 8'd11;
    localparam logic [7:0] OP_LAST = 8'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t            state_q, state_d;
    logic              alu_en_q, alu_en_d;
    logic [7:0]        alu_opcode_q, alu_opcode_d;
    logic [XLEN-1:0]   alu_operand1_q, alu_operand1_d;
    logic [XLEN-1:0]   alu_operand2_q, alu_operand2_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RW-1:0]     wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_div0_q, err_div0_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic [7:0]        dec_op;
    logic [RW-1:0]     dec_rd, dec_rs1, dec_rs2;
    logic [13:0]       dec_imm;
    logic              dec_legal, dec_uses_imm, div_zero, rf_we;
    logic [XLEN-1:0]   rs1_val, rs2_val, imm_sext;

    assign dec_op       = in_instr[31:24];
    assign dec_rd       = in_instr[23:19];
    assign dec_rs1      = in_instr[18:14];
    assign dec_rs2      = in_instr[13:9];
    assign dec_imm      = in_instr[13:0];
    assign dec_legal    = (dec_op <= OP_LAST);
    assign dec_uses_imm = (dec_op == OP_ADDI) || (dec_op == OP_LUI);
    assign rs1_val      = (dec_rs1 == '0) ? '0 : regs_q[dec_rs1];
    assign rs2_val      = (dec_rs2 == '0) ? '0 : regs_q[dec_rs2];
    assign imm_sext     = {{(XLEN-14){dec_imm[13]}}, dec_imm};
    // Divisor is checked on the latched operand, so the ALU's div-by-zero output is never trusted.
    assign div_zero     = (alu_opcode_q == OP_DIV) && (alu_operand2_q == '0);

    always_comb begin
        state_d        = state_q;
        alu_en_d       = 1'b0;
        alu_opcode_d   = alu_opcode_q;
        alu_operand1_d = alu_operand1_q;
        alu_operand2_d = alu_operand2_q;
        rd_d           = rd_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = '0;
        wb_data_d      = '0;
        err_illegal_d  = 1'b0;
        err_div0_d     = 1'b0;
        rf_we          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (dec_legal) begin
                        alu_en_d       = 1'b1;
                        alu_opcode_d   = dec_op;
                        alu_operand1_d = rs1_val;
                        alu_operand2_d = dec_uses_imm ? imm_sext : rs2_val;
                        rd_d           = dec_rd;
                        state_d        = S_EXEC;
                    end else begin
                        err_illegal_d  = 1'b1;
                    end
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = div_zero ? '1 : alu_result;
                err_div0_d = div_zero;
                rf_we      = (rd_q != '0);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            alu_en_q       <= 1'b0;
            alu_opcode_q   <= '0;
            alu_operand1_q <= '0;
            alu_operand2_q <= '0;
            rd_q           <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            err_illegal_q  <= 1'b0;
            err_div0_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            alu_en_q       <= alu_en_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_operand1_q <= alu_operand1_d;
            alu_operand2_q <= alu_operand2_d;
            rd_q           <= rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            err_illegal_q  <= err_illegal_d;
            err_div0_q     <= err_div0_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rd_q] <= wb_data_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign alu_en       = alu_en_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_operand1 = alu_operand1_q;
    assign alu_operand2 = alu_operand2_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign err_illegal  = err_illegal_q;
    assign err_div0     = err_div0_q;
    assign dbg_data     = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU plus an architectural register model
// drive directed and random instruction streams and check writeback, timing and errors.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        alu_en;
    logic [7:0]  alu_opcode;
    logic [63:0] alu_operand1, alu_operand2;
    logic [63:0] alu_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        err_illegal, err_div0;
    logic [4:0]  dbg_addr = '0;
    logic [63:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] mregs [32];

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .alu_en(alu_en), .alu_opcode(alu_opcode),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .err_illegal(err_illegal), .err_div0(err_div0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_alu(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            8'd0, 8'd1: return a + b;
            8'd2:       return a - b;
            8'd3:       return a * b;
            8'd4:       return (b == 0) ? 64'hDEAD_BEEF_0BAD_F00D : a / b;
            8'd5:       return a << b[5:0];
            8'd6:       return a >> b[5:0];
            8'd7:       return a & b;
            8'd8:       return a | b;
            8'd9:       return ~a;
            8'd10:      return a ^ b;
            8'd11:      return b << 12;
            default:    return 64'h0;
        endcase
    endfunction

    // External ALU: registered result one cycle after alu_en.
    always @(posedge clk) if (alu_en) alu_result <= ref_alu(alu_opcode, alu_operand1, alu_operand2);

    function automatic logic [31:0] rtype(input int op, input int rd, input int rs1, input int rs2);
        return {8'(op), 5'(rd), 5'(rs1), 5'(rs2), 9'd0};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rd, input int rs1, input int imm);
        return {8'(op), 5'(rd), 5'(rs1), 14'(imm)};
    endfunction

    task automatic model_exec(input logic [31:0] ins, output logic legal, output logic [63:0] res, output logic d0);
        int op, rd;
        logic [63:0] a, b;
        op = int'(ins[31:24]);
        rd = int'(ins[23:19]);
        legal = (op < 12);
        a = mregs[ins[18:14]];
        b = (op == 1 || op == 11) ? 64'($signed(ins[13:0])) : mregs[ins[13:9]];
        d0 = legal && (op == 4) && (b == 0);
        res = d0 ? 64'hFFFF_FFFF_FFFF_FFFF : ref_alu(8'(op), a, b);
        if (legal && rd != 0) mregs[rd] = res;
    endtask

    // Presents one instruction, returns at the negedge of the writeback (or error) cycle.
    task automatic issue(input logic [31:0] ins, output logic wv, output logic [4:0] wrd,
                         output logic [63:0] wdat, output logic d0, output logic ill,
                         output int lat, output int en_cnt, output logic [63:0] op2_seen,
                         output logic [63:0] dbg_seen, output logic rdy_after);
        int guard;
        wv = 0; wrd = 0; wdat = 0; d0 = 0; ill = 0; lat = 0; en_cnt = 0;
        op2_seen = 0; dbg_seen = 0; rdy_after = 0;
        guard = 0;
        while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL ready_timeout: in_ready got 0 want 1"); end
        dbg_addr = ins[23:19];
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = $urandom;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (alu_en) begin en_cnt++; op2_seen = alu_operand2; end
            if (wb_valid || err_div0) begin
                wv = wb_valid; wrd = wb_rd; wdat = wb_data; d0 = err_div0;
                dbg_seen = dbg_data; lat = k;
                break;
            end
            if (err_illegal) begin ill = 1; rdy_after = in_ready; lat = k; break; end
        end
    endtask

    task automatic test_reset;
        logic bad;
        checks++;
        if (in_ready !== 1'b1 || alu_en !== 1'b0 || wb_valid !== 1'b0 || err_illegal !== 1'b0 ||
            err_div0 !== 1'b0 || alu_opcode !== 8'h0 || alu_operand1 !== 64'h0 ||
            alu_operand2 !== 64'h0 || wb_rd !== 5'h0 || wb_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b en=%b wbv=%b ill=%b d0=%b op=%h wbd=%h want rdy=1 rest 0",
                     in_ready, alu_en, wb_valid, err_illegal, err_div0, alu_opcode, wb_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            if (dbg_data !== 64'h0) bad = 1;
            mregs[i] = 0;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_regs: got nonzero register want all 0"); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [31:0] ins [10];
        logic [63:0] ed [10];
        logic [63:0] eo [10];
        logic        edz [10];
        logic wv, d0, ill, rdy, lg, md;
        logic [4:0] wrd;
        logic [63:0] wdat, op2, dbgv, mres;
        int lat, enc;
        ins[0] = itype(1, 1, 0, 5);       ed[0] = 64'd5;   eo[0] = 64'd5;   edz[0] = 0;
        ins[1] = itype(1, 2, 0, 7);       ed[1] = 64'd7;   eo[1] = 64'd7;   edz[1] = 0;
        ins[2] = rtype(0, 3, 1, 2);       ed[2] = 64'd12;  eo[2] = 64'd7;   edz[2] = 0;
        ins[3] = itype(1, 1, 0, 'h3FFF);  ed[3] = '1;      eo[3] = '1;      edz[3] = 0;
        ins[4] = itype(11, 4, 0, 1);      ed[4] = 64'h1000; eo[4] = 64'd1;  edz[4] = 0;
        ins[5] = itype(1, 5, 0, 100);     ed[5] = 64'd100; eo[5] = 64'd100; edz[5] = 0;
        ins[6] = rtype(4, 6, 5, 0);       ed[6] = '1;      eo[6] = 64'd0;   edz[6] = 1;
        ins[7] = itype(1, 1, 0, 3);       ed[7] = 64'd3;   eo[7] = 64'd3;   edz[7] = 0;
        ins[8] = rtype(4, 7, 5, 1);       ed[8] = 64'd33;  eo[8] = 64'd3;   edz[8] = 0;
        ins[9] = itype(1, 0, 0, 9);       ed[9] = 64'd9;   eo[9] = 64'd9;   edz[9] = 0;
        for (int i = 0; i < 10; i++) begin
            issue(ins[i], wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
            model_exec(ins[i], lg, mres, md);
            checks++;
            if (wv !== 1'b1 || wdat !== ed[i] || wrd !== ins[i][23:19]) begin
                errors++;
                $display("FAIL dir_wb[%0d]: got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                         i, wv, wrd, wdat, ins[i][23:19], ed[i]);
            end
            checks++;
            if (op2 !== eo[i]) begin errors++; $display("FAIL dir_operand2[%0d]: got %h want %h", i, op2, eo[i]); end
            checks++;
            if (d0 !== edz[i]) begin errors++; $display("FAIL dir_div0[%0d]: got %b want %b", i, d0, edz[i]); end
            checks++;
            if (lat !== 3 || enc !== 1) begin
                errors++;
                $display("FAIL dir_timing[%0d]: got latency %0d alu_en cycles %0d want 3 and 1", i, lat, enc);
            end
            checks++;
            if (dbgv !== ((ins[i][23:19] == 0) ? 64'h0 : ed[i])) begin
                errors++; $display("FAIL dir_dbg[%0d]: got %h want %h", i, dbgv, ed[i]);
            end
        end
        dbg_addr = 5'd3; #1;
        checks++;
        if (dbg_data !== 64'd12) begin errors++; $display("FAIL dir_dbg_r3: got %h want 12", dbg_data); end
    endtask

    task automatic test_illegal;
        logic wv, d0, ill, rdy, bad;
        logic [4:0] wrd;
        logic [63:0] wdat, op2, dbgv;
        int lat, enc;
        logic [31:0] ins [2];
        ins[0] = itype(255, 3, 1, 0);
        ins[1] = itype(12, 2, 1, 0);
        for (int i = 0; i < 2; i++) begin
            issue(ins[i], wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
            checks++;
            if (ill !== 1'b1 || lat !== 1) begin
                errors++; $display("FAIL ill_pulse[%0d]: got ill=%b at cycle %0d want 1 at cycle 1", i, ill, lat);
            end
            checks++;
            if (enc !== 0 || wv !== 1'b0 || rdy !== 1'b1) begin
                errors++; $display("FAIL ill_side[%0d]: got alu_en=%0d wb=%b ready=%b want 0 0 1", i, enc, wv, rdy);
            end
            @(negedge clk);
            checks++;
            if (err_illegal !== 1'b0) begin errors++; $display("FAIL ill_width[%0d]: got %b want 0", i, err_illegal); end
        end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r); #1;
            if (dbg_data !== mregs[r]) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ill_regs: got register changed want unchanged"); end
    endtask

    task automatic test_back_to_back;
        logic wv, d0, ill, rdy, lg, md;
        logic [4:0] wrd;
        logic [63:0] wdat, op2, dbgv, mres;
        int lat, enc, prev;
        issue(itype(1, 10, 0, 1), wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
        model_exec(itype(1, 10, 0, 1), lg, mres, md);
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            issue(rtype(0, 10, 10, 10), wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
            model_exec(rtype(0, 10, 10, 10), lg, mres, md);
            checks++;
            if (cyc - prev !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, cyc - prev); end
            prev = cyc;
        end
        checks++;
        if (wdat !== 64'd16) begin errors++; $display("FAIL b2b_value: got %h want 16", wdat); end
    endtask

    task automatic test_reset_mid;
        logic saw_wb, bad;
        in_valid = 1'b1;
        in_instr = rtype(0, 3, 1, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_en !== 1'b1) begin errors++; $display("FAIL rst_mid_exec: alu_en got %b want 1", alu_en); end
        rst_n = 1'b0;
        saw_wb = 0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); if (wb_valid) saw_wb = 1; end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (wb_valid) saw_wb = 1; end
        checks++;
        if (saw_wb) begin errors++; $display("FAIL rst_mid_wb: got wb_valid 1 want 0"); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r); #1;
            if (dbg_data !== 64'h0) bad = 1;
            mregs[r] = 0;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rst_mid_regs: got nonzero want all 0"); end
    endtask

    task automatic test_held_valid;
        logic lg, md;
        logic [63:0] ea, eb, last;
        int accepts, acc_k, wbs;
        model_exec(itype(1, 8, 0, 11), lg, ea, md);
        model_exec(rtype(0, 9, 8, 8), lg, eb, md);
        in_valid = 1'b1;
        in_instr = itype(1, 8, 0, 11);
        @(posedge clk); #1;
        in_instr = rtype(0, 9, 8, 8);
        accepts = 0; acc_k = 0; wbs = 0; last = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wb_valid) begin wbs++; last = wb_data; end
            if (in_valid && in_ready) begin
                accepts++; acc_k = k;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        checks++;
        if (accepts !== 1 || acc_k !== 3) begin
            errors++; $display("FAIL held_accept: got %0d accepts at cycle %0d want 1 at cycle 3", accepts, acc_k);
        end
        checks++;
        if (wbs !== 2 || last !== eb) begin
            errors++; $display("FAIL held_wb: got %0d writes last %h want 2 last %h", wbs, last, eb);
        end
        dbg_addr = 5'd9; #1;
        checks++;
        if (dbg_data !== 64'd22) begin errors++; $display("FAIL held_dbg_r9: got %h want 22", dbg_data); end
    endtask

    task automatic test_random;
        logic wv, d0, ill, rdy, lg, md;
        logic [4:0] wrd;
        logic [63:0] wdat, op2, dbgv, mres;
        logic [31:0] ins;
        int lat, enc, op, rd, rs2;
        for (int r = 1; r < 32; r++) begin
            ins = itype(1, r, 0, int'($urandom_range(0, 16383)));
            issue(ins, wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
            model_exec(ins, lg, mres, md);
        end
        for (int i = 0; i < 80; i++) begin
            op  = int'($urandom_range(0, 14));
            rd  = int'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
            if (op == 1 || op == 11) ins = itype(op, rd, int'($urandom_range(0, 31)), int'($urandom_range(0, 16383)));
            else ins = rtype((op == 14) ? 200 : op, rd, int'($urandom_range(0, 31)), rs2);
            issue(ins, wv, wrd, wdat, d0, ill, lat, enc, op2, dbgv, rdy);
            model_exec(ins, lg, mres, md);
            if (lg) begin
                checks++;
                if (wv !== 1'b1 || wrd !== 5'(rd) || wdat !== mres || d0 !== md) begin
                    errors++;
                    $display("FAIL rnd_wb[%0d] op=%0d: got v=%b rd=%0d data=%h d0=%b want v=1 rd=%0d data=%h d0=%b",
                             i, op, wv, wrd, wdat, d0, rd, mres, md);
                end
                checks++;
                if (lat !== 3 || enc !== 1) begin
                    errors++; $display("FAIL rnd_timing[%0d]: got latency %0d en %0d want 3 1", i, lat, enc);
                end
                checks++;
                if (dbgv !== mregs[rd]) begin errors++; $display("FAIL rnd_dbg[%0d]: got %h want %h", i, dbgv, mregs[rd]); end
            end else begin
                checks++;
                if (ill !== 1'b1 || enc !== 0 || wv !== 1'b0 || rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_illegal[%0d]: got ill=%b en=%0d wb=%b rdy=%b want 1 0 0 1", i, ill, enc, wv, rdy);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_held_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
